cnt_seg_scan: RTL

- Downstream consumer of the two-stage JK ripple counter.
- Takes the counter's raw Q bits, which are asynchronous to clk because they come from the ripple clock domain.
- Synchronises and glitch-filters those bits and emits a clean count value plus a one-cycle update pulse.
- Drives a 4-digit multiplexed active-low seven-segment display: current count on digit 0, number of count updates mod 16 on digit 1.

---
 rtl/cnt_seg_scan.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cnt_seg_scan.sv
// Synchronises and glitch-filters ripple-counter Q bits, then scans a 4-digit active-low
// seven-segment display. Optional decimal-point blink after each update: CNT_DP_BLINK_EN.
module cnt_seg_scan #(
    parameter int CNT_W       = 2,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_val,
    output logic             upd,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] sync_p1, sync_p2, sync_p3;
    logic [3:0]       upd_cnt;
    logic [1:0]       slot;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_wrap;
    logic [3:0]       cnt_hex;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Stage p1..p3: two-flop synchroniser plus one-sample history for the stability filter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
            sync_p3 <= '0;
            cnt_val <= '0;
            upd     <= 1'b0;
        end else begin
            sync_p1 <= cnt_in;
            sync_p2 <= sync_p1;
            sync_p3 <= sync_p2;
            if (sync_p2 == sync_p3 && sync_p2 != cnt_val) begin
                cnt_val <= sync_p2;
                upd     <= 1'b1;
            end else begin
                upd     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            upd_cnt <= 4'd0;
        end else if (upd) begin
            upd_cnt <= upd_cnt + 4'd1;
        end
    end

    assign ref_wrap = (ref_cnt == REF_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ref_cnt <= '0;
            slot    <= 2'd0;
        end else if (ref_wrap) begin
            ref_cnt <= '0;
            slot    <= slot + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    always_comb begin
        cnt_hex = 4'd0;
        cnt_hex[CNT_W-1:0] = cnt_val;
    end

    // Display stage: an and seg come from the same slot sample, so a digit never tears
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an  <= 4'hF;
            seg <= 7'h7F;
        end else begin
            case (slot)
                2'd0: begin an <= 4'b1110; seg <= hex7(cnt_hex); end
                2'd1: begin an <= 4'b1101; seg <= hex7(upd_cnt); end
                2'd2: begin an <= 4'b1011; seg <= 7'h7F; end
                default: begin an <= 4'b0111; seg <= 7'h7F; end
            endcase
        end
    end

`ifdef CNT_DP_BLINK_EN
    localparam int HOLD_W = $clog2(4 * REFRESH_DIV + 1);

    logic [HOLD_W-1:0] hold;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hold <= '0;
            dp   <= 1'b1;
        end else begin
            if (upd) begin
                hold <= HOLD_W'(4 * REFRESH_DIV);
            end else if (hold != '0) begin
                hold <= hold - HOLD_W'(1);
            end
            dp <= !(slot == 2'd0 && hold != '0);
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule
